// File: rtl/ternary_pkg.sv
// Shared trit encoding, base-3 packing constants and unpacker FSM states.
// Pure declarations: no latency, no flow control.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_NEG  = 2'b00;
    localparam trit_t TRIT_ZERO = 2'b01;
    localparam trit_t TRIT_POS  = 2'b10;

    localparam int         TRITS_PER_BYTE = 5;
    localparam logic [7:0] PACK_MAX       = 8'd242;
    localparam logic [7:0] PACK_ZERO      = 8'd121;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_OUT
    } state_e;

endpackage

// File: rtl/trit_divmod3.sv
// Combinational split of a byte into quotient and remainder by 3 (one base-3 digit).
// Zero latency, no flow control; multiply-by-171 >> 9 is exact for inputs below 512.
module trit_divmod3
    import ternary_pkg::*;
(
    input  logic [7:0] r_i,
    output logic [7:0] quot_o,
    output trit_t      rem_o
);

    assign quot_o = 8'(({8'd0, r_i} * 16'd171) >> 9);
    assign rem_o  = 2'(r_i - 8'(quot_o * 8'd3));

endmodule

// File: rtl/ternary_weight_unpacker.sv
// Unpacks base-3 packed weight bytes (5 trits each) into LANES-wide trit beats; TRIT_STATS_EN adds trit counters.
// One trit per cycle, beat valid the cycle after the filling trit; input stalls while unpacking or holding a beat.
module ternary_weight_unpacker
    import ternary_pkg::*;
#(
    parameter int LANES  = 27,
    parameter int STAT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [7:0]                 s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [2*LANES-1:0]         m_data,
    output logic [$clog2(LANES+1)-1:0] m_count,
    output logic                       m_last,
    output logic                       err_invalid,
    input  logic                       err_clear
`ifdef TRIT_STATS_EN
    ,
    input  logic                       stat_clear,
    output logic [STAT_W-1:0]          stat_neg,
    output logic [STAT_W-1:0]          stat_zero,
    output logic [STAT_W-1:0]          stat_pos
`endif
);

    localparam int                 CW         = $clog2(LANES + 1);
    localparam logic [2*LANES-1:0] LANES_IDLE = {LANES{TRIT_ZERO}};

    if (LANES < 1 || LANES > 64 || STAT_W < 1) begin : g_bad_param
        $error("ternary_weight_unpacker: illegal LANES/STAT_W");
    end

    state_e             state_q, state_d;
    logic [7:0]         r_q, r_d;
    logic [2:0]         dig_q, dig_d;
    logic               last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*LANES-1:0] lanes_q, lanes_d;
    logic               err_q, err_d;
    logic               rdy_q;

    logic [7:0] quot;
    trit_t      rem;
    logic       s_fire, bad_byte, dig_done, grp_full;

    trit_divmod3 u_divmod3 (
        .r_i    (r_q),
        .quot_o (quot),
        .rem_o  (rem)
    );

    assign s_ready  = rdy_q & (state_q == ST_IDLE);
    assign s_fire   = s_ready & s_valid;
    assign bad_byte = s_data > PACK_MAX;
    assign dig_done = dig_q == 3'd1;
    assign grp_full = cnt_q == CW'(LANES - 1);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dig_d   = dig_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    state_d = ST_UNPACK;
                    r_d     = bad_byte ? PACK_ZERO : s_data;
                    dig_d   = 3'(TRITS_PER_BYTE);
                    last_d  = s_last;
                end
            end
            ST_UNPACK: begin
                for (int i = 0; i < LANES; i++) begin
                    if (CW'(i) == cnt_q) lanes_d[2*i +: 2] = rem;
                end
                r_d   = quot;
                cnt_d = cnt_q + 1'b1;
                dig_d = dig_q - 3'd1;
                if (grp_full || (dig_done && last_q)) state_d = ST_OUT;
                else if (dig_done)                    state_d = ST_IDLE;
            end
            ST_OUT: begin
                if (m_ready) begin
                    lanes_d = LANES_IDLE;
                    cnt_d   = '0;
                    state_d = (dig_q != 3'd0) ? ST_UNPACK : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new invalid byte must not be lost to a same-cycle clear.
    assign err_d = (err_q & ~err_clear) | (s_fire & bad_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            dig_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            lanes_q <= LANES_IDLE;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dig_q   <= dig_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    assign m_valid     = state_q == ST_OUT;
    assign m_data      = lanes_q;
    assign m_count     = cnt_q;
    assign m_last      = m_valid & last_q & (dig_q == 3'd0);
    assign err_invalid = err_q;

`ifdef TRIT_STATS_EN
    logic [STAT_W-1:0] neg_q, zero_q, pos_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q  <= '0;
            zero_q <= '0;
            pos_q  <= '0;
        end else if (stat_clear) begin
            neg_q  <= '0;
            zero_q <= '0;
            pos_q  <= '0;
        end else if (state_q == ST_UNPACK) begin
            case (rem)
                TRIT_NEG:  if (~&neg_q)  neg_q  <= neg_q + 1'b1;
                TRIT_ZERO: if (~&zero_q) zero_q <= zero_q + 1'b1;
                TRIT_POS:  if (~&pos_q)  pos_q  <= pos_q + 1'b1;
                default:   ;
            endcase
        end
    end

    assign stat_neg  = neg_q;
    assign stat_zero = zero_q;
    assign stat_pos  = pos_q;
`endif

endmodule

// File: tb/tb_ternary_weight_unpacker.sv
// Directed bench: a LANES=5 and a LANES=27 instance sharing clock and reset.
module tb_ternary_weight_unpacker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last, a_err, a_err_clear;
    logic [7:0]  a_s_data;
    logic [9:0]  a_m_data;
    logic [2:0]  a_m_count;
    logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last, b_err, b_err_clear;
    logic [7:0]  b_s_data;
    logic [53:0] b_m_data;
    logic [4:0]  b_m_count;
`ifdef TRIT_STATS_EN
    logic        a_stat_clear, b_stat_clear;
    logic [31:0] a_stat_neg, a_stat_zero, a_stat_pos, b_stat_neg, b_stat_zero, b_stat_pos;
`endif

    ternary_weight_unpacker #(.LANES(5), .STAT_W(32)) u_a (
        .clk(clk), .reset(reset),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_count(a_m_count),
        .m_last(a_m_last), .err_invalid(a_err), .err_clear(a_err_clear)
`ifdef TRIT_STATS_EN
        , .stat_clear(a_stat_clear), .stat_neg(a_stat_neg), .stat_zero(a_stat_zero), .stat_pos(a_stat_pos)
`endif
    );

    ternary_weight_unpacker #(.LANES(27), .STAT_W(32)) u_b (
        .clk(clk), .reset(reset),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_count(b_m_count),
        .m_last(b_m_last), .err_invalid(b_err), .err_clear(b_err_clear)
`ifdef TRIT_STATS_EN
        , .stat_clear(b_stat_clear), .stat_neg(b_stat_neg), .stat_zero(b_stat_zero), .stat_pos(b_stat_pos)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic l);
        int n = 0;
        if (sel) begin b_s_valid = 1'b1; b_s_data = d; b_s_last = l; end
        else     begin a_s_valid = 1'b1; a_s_data = d; a_s_last = l; end
        while (!(sel ? b_s_ready : a_s_ready) && n < 50) begin
            tick();
            n++;
        end
        chk("send_rdy", sel ? b_s_ready : a_s_ready, 1'b1);
        tick();
        a_s_valid = 1'b0;
        b_s_valid = 1'b0;
    endtask

    task automatic wait_beat(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? b_m_valid : a_m_valid) && lat < 60) begin
            tick();
            lat++;
        end
        chk("beat_vld", sel ? b_m_valid : a_m_valid, 1'b1);
    endtask

    task automatic take(input bit sel);
        if (sel) b_m_ready = 1'b1; else a_m_ready = 1'b1;
        tick();
        a_m_ready = 1'b0;
        b_m_ready = 1'b0;
        chk("take_clr", sel ? b_m_valid : a_m_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [53:0] b_idle, b_exp;
        b_idle = {27{2'b01}};
        reset = 1'b1;
        a_s_valid = 0; a_s_data = 0; a_s_last = 0; a_m_ready = 0; a_err_clear = 0;
        b_s_valid = 0; b_s_data = 0; b_s_last = 0; b_m_ready = 0; b_err_clear = 0;
`ifdef TRIT_STATS_EN
        a_stat_clear = 0; b_stat_clear = 0;
`endif
        repeat (3) tick();

        // Reset state
        chk("rst_s_ready", a_s_ready, 1'b0);
        chk("rst_m_valid", a_m_valid, 1'b0);
        chk("rst_m_count", a_m_count, 3'd0);
        chk("rst_m_last",  a_m_last, 1'b0);
        chk("rst_err",     a_err, 1'b0);
        chk("rst_m_data",  a_m_data, 10'h155);
        chk("rst_b_data",  b_m_data, b_idle);
        chk("rst_b_ready", b_s_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk("rel_s_ready",   a_s_ready, 1'b1);
        chk("rel_b_s_ready", b_s_ready, 1'b1);

        // LANES=5, 0xF2 last: exact fill, then no empty beat
        send(0, 8'hF2, 1'b1);
        wait_beat(0, lat);
        chk("f2_latency", lat, 5);
        chk("f2_data",  a_m_data, 10'h2AA);
        chk("f2_count", a_m_count, 3'd5);
        chk("f2_last",  a_m_last, 1'b1);
        take(0);
        tick();
        chk("f2_no_empty", a_m_valid, 1'b0);

        // LANES=5, 0x05 last
        send(0, 8'h05, 1'b1);
        wait_beat(0, lat);
        chk("05_data",  a_m_data, 10'h006);
        chk("05_count", a_m_count, 3'd5);
        chk("05_last",  a_m_last, 1'b1);
        take(0);

        // LANES=27, six 0xF2 bytes: full beat then 3-trit tail
        for (int i = 0; i < 5; i++) send(1, 8'hF2, 1'b0);
        send(1, 8'hF2, 1'b1);
        wait_beat(1, lat);
        chk("b1_data",  b_m_data, {27{2'b10}});
        chk("b1_count", b_m_count, 5'd27);
        chk("b1_last",  b_m_last, 1'b0);
        take(1);
        wait_beat(1, lat);
        chk("b2_data",  b_m_data, {{24{2'b01}}, {3{2'b10}}});
        chk("b2_count", b_m_count, 5'd3);
        chk("b2_last",  b_m_last, 1'b1);
        take(1);

        // LANES=27, last byte while a partial group is pending
        send(1, 8'h05, 1'b0);
        send(1, 8'h05, 1'b0);
        send(1, 8'hF2, 1'b1);
        wait_beat(1, lat);
        b_exp = {{12{2'b01}}, {5{2'b10}}, 10'b00_00_00_01_10, 10'b00_00_00_01_10};
        chk("b3_data",  b_m_data, b_exp);
        chk("b3_count", b_m_count, 5'd15);
        chk("b3_last",  b_m_last, 1'b1);
        chk("b3_err",   b_err, 1'b0);
        take(1);

        // Invalid byte, sticky flag, clear, set-wins
        send(0, 8'hF3, 1'b1);
        chk("inv_err_set", a_err, 1'b1);
        wait_beat(0, lat);
        chk("inv_data",  a_m_data, 10'h155);
        chk("inv_count", a_m_count, 3'd5);
        chk("inv_last",  a_m_last, 1'b1);
        take(0);
        chk("inv_sticky", a_err, 1'b1);
        a_err_clear = 1'b1;
        tick();
        a_err_clear = 1'b0;
        chk("inv_cleared", a_err, 1'b0);
        a_err_clear = 1'b1;
        send(0, 8'hF4, 1'b1);
        a_err_clear = 1'b0;
        chk("inv_set_wins", a_err, 1'b1);
        wait_beat(0, lat);
        chk("inv2_data", a_m_data, 10'h155);
        take(0);
        a_err_clear = 1'b1;
        tick();
        a_err_clear = 1'b0;
        chk("inv2_cleared", a_err, 1'b0);

        // Backpressure: beat held stable for 10 cycles
        send(0, 8'h05, 1'b1);
        wait_beat(0, lat);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", a_m_valid, 1'b1);
            chk("hold_data",  a_m_data, 10'h006);
            chk("hold_count", a_m_count, 3'd5);
            chk("hold_last",  a_m_last, 1'b1);
            chk("hold_s_rdy", a_s_ready, 1'b0);
            tick();
        end
        take(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_once", a_m_valid, 1'b0);
        end

        // Reset in the third UNPACK cycle
        send(0, 8'hF2, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", a_m_valid, 1'b0);
        chk("mid_rst_rdy",   a_s_ready, 1'b0);
        chk("mid_rst_data",  a_m_data, 10'h155);
        chk("mid_rst_count", a_m_count, 3'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_rdy", a_s_ready, 1'b1);
        send(0, 8'h05, 1'b1);
        wait_beat(0, lat);
        chk("post_rst_data",  a_m_data, 10'h006);
        chk("post_rst_count", a_m_count, 3'd5);
        chk("post_rst_last",  a_m_last, 1'b1);
`ifdef TRIT_STATS_EN
        chk("stat_neg",  a_stat_neg, 32'd3);
        chk("stat_zero", a_stat_zero, 32'd1);
        chk("stat_pos",  a_stat_pos, 32'd1);
`endif
        take(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_once", a_m_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
